// File: rtl/count_capture_pkg.sv
// Shared widths and timestamp type for the counter event-capture block.
package count_capture_pkg;

  localparam int CNT_W_DEF   = 3;
  localparam int EPOCH_W_DEF = 5;
  localparam int TS_W        = EPOCH_W_DEF + CNT_W_DEF;

  typedef logic [TS_W-1:0] ts_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous show-ahead FIFO: the oldest entry is always visible on
// rd_data while valid is high. Callers gate wr_en/rd_en against full/valid.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;

  // Storage array; contents need no reset because level_r gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

  assign valid   = (level_r != '0);
  assign full    = (level_r == LVL_MAX);
  assign level   = level_r;
  assign rd_data = valid ? mem_r[rd_ptr_r] : '0;

endmodule

// File: rtl/count_event_capture.sv
// Captures the upstream free-running counter on each rising edge of an
// asynchronous event, extends it with a wrap (epoch) count and queues the
// timestamps for a valid/ready consumer. Dropped events set a sticky flag.
// Build option: COUNT_CAPTURE_EPOCH_EN enables the epoch counter and wrap
// detection; without it the epoch field of ts_data is tied to zero.
module count_event_capture
  import count_capture_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int EPOCH_W = EPOCH_W_DEF,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           count_in,
  input  logic                       event_in,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [EPOCH_W+CNT_W-1:0]   ts_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_ovf
);

  logic                     s1_r;
  logic                     s2_r;
  logic                     s3_r;
  logic                     capture_s;
  logic                     pop_s;
  logic                     full_s;
  logic                     wr_en_s;
  logic                     drop_s;
  logic                     overflow_r;
  logic [EPOCH_W-1:0]       epoch_nxt_s;
  logic [EPOCH_W+CNT_W-1:0] ts_s;

  // Two-flop synchroniser plus history flop; preset high so a level held
  // through reset does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b1;
      s2_r <= 1'b1;
      s3_r <= 1'b1;
    end else begin
      s1_r <= event_in;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign capture_s = s2_r & ~s3_r;
  assign pop_s     = ts_valid & ts_ready;
  assign wr_en_s   = capture_s & (~full_s | pop_s);
  assign drop_s    = capture_s & full_s & ~pop_s;

`ifdef COUNT_CAPTURE_EPOCH_EN
  logic [CNT_W-1:0]   prev_cnt_r;
  logic [EPOCH_W-1:0] epoch_r;
  logic               wrap_s;

  // Only an all-ones to zero step is a wrap; other drops (upstream reset) are not.
  always_comb begin
    wrap_s      = 1'b0;
    epoch_nxt_s = epoch_r;
    if ((prev_cnt_r == {CNT_W{1'b1}}) && (count_in == '0)) begin
      wrap_s      = 1'b1;
      epoch_nxt_s = epoch_r + EPOCH_W'(1);
    end else begin
      wrap_s      = 1'b0;
      epoch_nxt_s = epoch_r;
    end
  end

  // Track last count and advance the epoch (modulo 2^EPOCH_W) on a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_cnt_r <= '0;
      epoch_r    <= '0;
    end else begin
      prev_cnt_r <= count_in;
      if (wrap_s) begin
        epoch_r <= epoch_nxt_s;
      end
    end
  end
`else
  assign epoch_nxt_s = '0;
`endif

  // Use the post-wrap epoch so a capture on the wrap cycle stays consistent.
  assign ts_s = {epoch_nxt_s, count_in};

  // Sticky drop flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end
  end

  assign overflow = overflow_r;

  sync_fifo #(
    .WIDTH (EPOCH_W + CNT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en_s),
    .wr_data (ts_s),
    .rd_en   (pop_s),
    .rd_data (ts_data),
    .valid   (ts_valid),
    .full    (full_s),
    .level   (level)
  );

endmodule

// File: tb/tb_count_event_capture.sv
// Directed bench for count_event_capture: stimulus pushes expected timestamps
// into a queue, a negedge monitor pops and compares whenever a pop happens.
module tb_count_event_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count_in;
  logic       event_in;
  logic       ts_valid;
  logic       ts_ready;
  logic [7:0] ts_data;
  logic [2:0] level;
  logic       overflow;
  logic       clear_ovf;

  always #5 clk = ~clk;

  count_event_capture #(
    .CNT_W   (3),
    .EPOCH_W (5),
    .DEPTH   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .event_in  (event_in),
    .ts_valid  (ts_valid),
    .ts_ready  (ts_ready),
    .ts_data   (ts_data),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  logic [7:0] exp_q [$];
  logic [7:0] exp_v;
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic void check(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Expected timestamp for the current build.
  function automatic logic [7:0] mk_ts(int ep, int cnt);
    logic [7:0] r;
`ifdef COUNT_CAPTURE_EPOCH_EN
    r = {ep[4:0], cnt[2:0]};
`else
    r = {5'd0, cnt[2:0]};
`endif
    return r;
  endfunction

  // Monitor: every accepted entry must match the oldest expected timestamp.
  always @(negedge clk) begin
    if (!rst && ts_valid && ts_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_pop: got 0x%0h expected no entry", ts_data);
      end else begin
        exp_v = exp_q.pop_front();
        check("pop_data", int'(ts_data), int'(exp_v));
`ifndef COUNT_CAPTURE_EPOCH_EN
        check("epoch_bits_zero", int'(ts_data[7:3]), 0);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One event pulse (2 cycles high, 2 low); the write uses c2.
  task automatic capture_seq(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
    event_in = 1'b1;
    count_in = c0;
    tick();
    count_in = c1;
    tick();
    event_in = 1'b0;
    count_in = c2;
    tick();
    tick();
  endtask

  task automatic capture(input logic [2:0] c);
    capture_seq(c, c, c);
  endtask

  task automatic drain(input int n);
    ts_ready = 1'b1;
    repeat (n) tick();
    ts_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    event_in  = 1'b0;
    count_in  = 3'd0;
    ts_ready  = 1'b0;
    clear_ovf = 1'b0;
    repeat (3) tick();
    check("rst_valid", int'(ts_valid), 0);
    check("rst_data", int'(ts_data), 0);
    check("rst_level", int'(level), 0);
    check("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    tick();

    // Basic capture of count 5 with epoch 0.
    exp_q.push_back(mk_ts(0, 5));
    capture(3'd5);
    check("s1_valid", int'(ts_valid), 1);
    check("s1_level", int'(level), 1);
    check("s1_data", int'(ts_data), int'(mk_ts(0, 5)));
    drain(1);
    check("s1_level_after_pop", int'(level), 0);
    check("s1_valid_after_pop", int'(ts_valid), 0);

    // Capture on the wrap cycle: 6,7,0 -> epoch 1, count 0.
    exp_q.push_back(mk_ts(1, 0));
    capture_seq(3'd6, 3'd7, 3'd0);
    check("wrap_level", int'(level), 1);
    drain(1);

    // Five events with no consumer: four stored, one dropped.
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(mk_ts(1, k));
      capture(3'(k));
    end
    check("ovf_level", int'(level), 4);
    check("ovf_flag", int'(overflow), 1);
    check("ovf_valid", int'(ts_valid), 1);
    drain(4);
    check("ovf_drained_level", int'(level), 0);
    check("ovf_still_set", int'(overflow), 1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    check("ovf_cleared", int'(overflow), 0);

    // Full FIFO with capture and pop in the same cycle.
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(mk_ts(1, k));
      capture(3'(k));
    end
    check("full_level", int'(level), 4);
    exp_q.push_back(mk_ts(1, 6));
    event_in = 1'b1;
    count_in = 3'd6;
    tick();
    tick();
    event_in = 1'b0;
    ts_ready = 1'b1;
    tick();
    ts_ready = 1'b0;
    tick();
    check("full_pushpop_level", int'(level), 4);
    check("full_pushpop_ovf", int'(overflow), 0);
    drain(4);
    check("full_drained_level", int'(level), 0);
    check("full_queue_empty", exp_q.size(), 0);

    // Reset mid-operation discards contents; event held through reset is ignored.
    capture(3'd2);
    check("pre_rst_level", int'(level), 1);
    rst      = 1'b1;
    event_in = 1'b1;
    count_in = 3'd3;
    repeat (3) tick();
    check("mid_rst_level", int'(level), 0);
    rst = 1'b0;
    repeat (4) tick();
    check("held_event_level", int'(level), 0);
    check("held_event_valid", int'(ts_valid), 0);
    event_in = 1'b0;
    tick();
    tick();
    exp_q.push_back(mk_ts(0, 3));
    capture(3'd3);
    check("rearm_level", int'(level), 1);
    tick();
    tick();
    check("rearm_single", int'(level), 1);
    drain(1);
    check("final_level", int'(level), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
